// File: rtl/up_pack_pkg.sv
// Shared types and constants for the uplink frame packer.
package up_pack_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        SEQ,
        LEN,
        PAY,
        CHK
    } pack_state_t;

    localparam logic [15:0] HDR_DEFAULT    = 16'hAA55;
    localparam int          BYTE_W         = 8;
    localparam int          WORD_W         = 64;
    localparam int          BYTES_PER_WORD = 8;

    // Byte idx of a word, MSB byte first (idx 0 -> w[63:56]).
    function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                    input logic [2:0]        idx);
        return w[BYTE_W*(BYTES_PER_WORD-1-int'(idx)) +: BYTE_W];
    endfunction

endpackage

// File: rtl/up_sync_fifo.sv
// Show-ahead synchronous FIFO; exposes the head word and the word behind it
// so the packer can switch payload words without a bubble.
module up_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                       rdclk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [WIDTH-1:0]           next_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok     = push && !full;
    assign pop_ok      = pop && !empty;
    assign rd_ptr_next = rd_ptr_reg + 1'b1;

    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign head_data = mem[rd_ptr_reg];
    assign next_data = mem[rd_ptr_next];

    always_ff @(posedge rdclk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge rdclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_next;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/up_frame_packer.sv
// Packs polled 64-bit words into byte-serial HDR/SEQ/LEN/payload uplink frames.
// Build option UP_PACK_CHKSUM_EN appends a wrapping-sum CHK byte to each frame.
module up_frame_packer
    import up_pack_pkg::*;
#(
    parameter int          FIFO_DEPTH      = 16,
    parameter int          WORDS_PER_FRAME = 4,
    parameter int          TIMEOUT         = 1000,
    parameter logic [15:0] HDR             = HDR_DEFAULT
) (
    input  logic        rdclk,
    input  logic        rst_n,
    input  logic        data_valid,
    input  logic [63:0] up_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        frame_busy,
    output logic        overflow,
    output logic [15:0] drop_cnt
);
    localparam int                CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int                TO_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  WPF_C   = CNT_W'(WORDS_PER_FRAME);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

    pack_state_t       state_reg;
    logic              tx_valid_reg;
    logic              frame_busy_reg;
    logic              overflow_reg;
    logic [7:0]        tx_data_reg;
    logic [7:0]        seq_reg;
    logic [7:0]        len_reg;
    logic [7:0]        word_idx_reg;
    logic [7:0]        chk_reg;
    logic [2:0]        byte_idx_reg;
    logic [15:0]       drop_cnt_reg;
    logic [TO_W-1:0]   to_cnt_reg;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [WORD_W-1:0] head_data;
    logic [WORD_W-1:0] next_data;
    logic              push_ok;
    logic              pop;
    logic              xfer;
    logic              last_word;
    logic              full_frame;

    assign push_ok    = data_valid && !fifo_full;
    assign xfer       = tx_valid_reg && tx_ready;
    assign last_word  = (word_idx_reg + 8'd1) == len_reg;
    assign pop        = (state_reg == PAY) && xfer && (byte_idx_reg == 3'd7);
    assign full_frame = (fifo_count >= WPF_C);

    assign tx_valid   = tx_valid_reg;
    assign tx_data    = tx_data_reg;
    assign frame_busy = frame_busy_reg;
    assign overflow   = overflow_reg;
    assign drop_cnt   = drop_cnt_reg;

    up_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .rdclk     (rdclk),
        .rst_n     (rst_n),
        .push      (push_ok),
        .push_data (up_data),
        .pop       (pop),
        .head_data (head_data),
        .next_data (next_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge rdclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            tx_valid_reg   <= 1'b0;
            tx_data_reg    <= 8'h00;
            frame_busy_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            drop_cnt_reg   <= 16'h0000;
            seq_reg        <= 8'h00;
            len_reg        <= 8'h00;
            word_idx_reg   <= 8'h00;
            byte_idx_reg   <= 3'd0;
            chk_reg        <= 8'h00;
            to_cnt_reg     <= '0;
        end else begin
            if (data_valid && fifo_full) begin
                overflow_reg <= 1'b1;
                if (drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end

            case (state_reg)
                IDLE: begin
                    if (full_frame || (!fifo_empty && to_cnt_reg == TO_LAST)) begin
                        len_reg        <= full_frame ? 8'(WORDS_PER_FRAME) : 8'(fifo_count);
                        state_reg      <= HDR0;
                        tx_valid_reg   <= 1'b1;
                        frame_busy_reg <= 1'b1;
                        tx_data_reg    <= HDR[7:0];
                        to_cnt_reg     <= '0;
                    end else if (push_ok || fifo_empty) begin
                        to_cnt_reg <= '0;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                HDR0: if (xfer) begin
                    state_reg   <= HDR1;
                    tx_data_reg <= HDR[15:8];
                end
                HDR1: if (xfer) begin
                    state_reg   <= SEQ;
                    tx_data_reg <= seq_reg;
                end
                SEQ: if (xfer) begin
                    state_reg   <= LEN;
                    tx_data_reg <= len_reg;
                    chk_reg     <= tx_data_reg;
                end
                LEN: if (xfer) begin
                    state_reg    <= PAY;
                    tx_data_reg  <= word_byte(head_data, 3'd0);
                    chk_reg      <= chk_reg + tx_data_reg;
                    byte_idx_reg <= 3'd0;
                    word_idx_reg <= 8'h00;
                end
                PAY: if (xfer) begin
                    chk_reg      <= chk_reg + tx_data_reg;
                    byte_idx_reg <= byte_idx_reg + 3'd1;
                    if (byte_idx_reg != 3'd7) begin
                        tx_data_reg <= word_byte(head_data, byte_idx_reg + 3'd1);
                    end else if (!last_word) begin
                        // head is popped on this edge; next_data becomes the new head
                        word_idx_reg <= word_idx_reg + 8'd1;
                        tx_data_reg  <= word_byte(next_data, 3'd0);
                    end else begin
`ifdef UP_PACK_CHKSUM_EN
                        state_reg   <= CHK;
                        tx_data_reg <= chk_reg + tx_data_reg;
`else
                        state_reg      <= IDLE;
                        tx_valid_reg   <= 1'b0;
                        frame_busy_reg <= 1'b0;
                        seq_reg        <= seq_reg + 8'd1;
`endif
                    end
                end
`ifdef UP_PACK_CHKSUM_EN
                CHK: if (xfer) begin
                    state_reg      <= IDLE;
                    tx_valid_reg   <= 1'b0;
                    frame_busy_reg <= 1'b0;
                    seq_reg        <= seq_reg + 8'd1;
                end
`endif
                default: begin
                    state_reg      <= IDLE;
                    tx_valid_reg   <= 1'b0;
                    frame_busy_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_up_frame_packer.sv
// Self-checking bench for up_frame_packer: byte scoreboard fed by a frame model,
// a vector table of frame shapes, and hand sequences for the multi-cycle corners.
module tb_up_frame_packer;
    localparam int TIMEOUT = 1000;
    localparam int WPF     = 4;
`ifdef UP_PACK_CHKSUM_EN
    localparam int CHK_B = 1;
`else
    localparam int CHK_B = 0;
`endif
    localparam int FLEN4 = 4 + 8*WPF + CHK_B;

    typedef struct {
        int          nwords;
        logic [63:0] seed;
        int          exp_bytes;
    } vec_t;

    logic        rdclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_valid = 1'b0;
    logic [63:0] up_data = '0;
    logic        tx_ready = 1'b0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        frame_busy;
    logic        overflow;
    logic [15:0] drop_cnt;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          bytes_seen = 0;
    int          b0;
    int          start;
    int          stall_bad;
    logic [7:0]  model_seq = 8'h00;
    logic [7:0]  exp_b;
    logic [7:0]  held;
    logic [63:0] w;
    logic [7:0]  exp_q[$];
    logic [63:0] pend_q[$];
    vec_t        vecs[5];

    up_frame_packer #(
        .FIFO_DEPTH      (16),
        .WORDS_PER_FRAME (WPF),
        .TIMEOUT         (TIMEOUT),
        .HDR             (16'hAA55)
    ) dut (
        .rdclk      (rdclk),
        .rst_n      (rst_n),
        .data_valid (data_valid),
        .up_data    (up_data),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .frame_busy (frame_busy),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 rdclk = ~rdclk;
    always @(posedge rdclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Transfers are judged half a cycle before the edge that completes them.
    always @(negedge rdclk) begin
        if (rst_n && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL tx_unexpected: got byte %02h, expected none", tx_data);
            end else begin
                exp_b = exp_q.pop_front();
                check("tx_byte", tx_data, exp_b);
                check("frame_busy", frame_busy, 1'b1);
            end
            bytes_seen++;
        end
    end

    // Reference framing: split pending words into frames of up to WPF words.
    task automatic flush_frames();
        int         n;
        logic [7:0] sum;
        logic [7:0] b;
        logic [63:0] wd;
        while (pend_q.size() != 0) begin
            n = (pend_q.size() > WPF) ? WPF : pend_q.size();
            exp_q.push_back(8'h55);
            exp_q.push_back(8'hAA);
            exp_q.push_back(model_seq);
            exp_q.push_back(8'(n));
            sum = model_seq + 8'(n);
            for (int i = 0; i < n; i++) begin
                wd = pend_q.pop_front();
                for (int k = 7; k >= 0; k--) begin
                    b = wd[8*k +: 8];
                    exp_q.push_back(b);
                    sum = sum + b;
                end
            end
`ifdef UP_PACK_CHKSUM_EN
            exp_q.push_back(sum);
`endif
            $display("frame queued: seq=%02h len=%0d chk=%02h", model_seq, n, sum);
            model_seq = model_seq + 8'd1;
        end
    endtask

    task automatic push_word(input logic [63:0] wd);
        data_valid = 1'b1;
        up_data    = wd;
        @(posedge rdclk); #1;
        data_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0 && !tx_valid) break;
            @(posedge rdclk); #1;
        end
        n_checks++;
        if (i < max_cyc) n_pass++;
        else $display("FAIL drain_timeout: got %0d bytes outstanding, expected 0", exp_q.size());
    endtask

    task automatic wait_bytes(input int target, input int max_cyc);
        for (int i = 0; i < max_cyc && bytes_seen < target; i++) begin
            @(posedge rdclk); #1;
        end
    endtask

    initial begin
        vecs[0] = '{4, 64'h0102030405060708, FLEN4};
        vecs[1] = '{4, 64'hF0E1D2C3B4A59687, FLEN4};
        vecs[2] = '{1, 64'h1122334455667788, 4 + 8 + CHK_B};
        vecs[3] = '{3, 64'hCAFEBABE00000001, 4 + 24 + CHK_B};
        vecs[4] = '{5, 64'h8000000000000001, FLEN4 + 4 + 8 + CHK_B};

        // Reset values
        tx_ready = 1'b1;
        repeat (3) @(posedge rdclk);
        #1;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_frame_busy", frame_busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_drop_cnt", drop_cnt, 16'h0000);
        rst_n = 1'b1;
        @(posedge rdclk); #1;

        // Vector table: full frames, timeout frames, full frame plus leftover
        for (int v = 0; v < 5; v++) begin
            b0 = bytes_seen;
            for (int i = 0; i < vecs[v].nwords; i++) begin
                w = vecs[v].seed + 64'h0808080808080808 * 64'(i);
                push_word(w);
                pend_q.push_back(w);
            end
            flush_frames();
            wait_drain(3000);
            check("vec_bytes", bytes_seen - b0, vecs[v].exp_bytes);
        end

        // Timeout latency from a single word
        start = cyc;
        w = {$urandom, $urandom};
        push_word(w);
        pend_q.push_back(w);
        flush_frames();
        for (int i = 0; i < 1200 && !tx_valid; i++) begin
            @(posedge rdclk); #1;
        end
        check("timeout_latency", cyc - start, 1001);
        wait_drain(100);

        // tx_ready stall mid-payload
        b0 = bytes_seen;
        for (int i = 0; i < 4; i++) begin
            w = {$urandom, $urandom};
            push_word(w);
            pend_q.push_back(w);
        end
        flush_frames();
        wait_bytes(b0 + 12, 200);
        tx_ready  = 1'b0;
        held      = tx_data;
        stall_bad = 0;
        repeat (20) begin
            @(posedge rdclk); #1;
            if (tx_data !== held || tx_valid !== 1'b1) stall_bad++;
        end
        check("stall_hold", stall_bad, 0);
        check("stall_count", bytes_seen - b0, 12);
        tx_ready = 1'b1;
        wait_drain(200);
        check("stall_total", bytes_seen - b0, FLEN4);

        // Overflow: 40 back-to-back words with the uplink stalled
        tx_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            w = {$urandom, $urandom};
            if (i < 16) pend_q.push_back(w);
            data_valid = 1'b1;
            up_data    = w;
            @(posedge rdclk); #1;
        end
        data_valid = 1'b0;
        check("ovf_drop_cnt", drop_cnt, 16'd24);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_tx_valid", tx_valid, 1'b1);
        check("ovf_hdr0_held", tx_data, 8'h55);
        flush_frames();
        start    = cyc;
        tx_ready = 1'b1;
        wait_drain(400);
        check("b2b_cycles", cyc - start, 4*FLEN4 + 3);
        check("ovf_sticky", overflow, 1'b1);

        // Reset mid-payload
        b0 = bytes_seen;
        for (int i = 0; i < 4; i++) begin
            w = {$urandom, $urandom};
            push_word(w);
            pend_q.push_back(w);
        end
        flush_frames();
        wait_bytes(b0 + 10, 200);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_valid", tx_valid, 1'b0);
        check("mid_rst_tx_data", tx_data, 8'h00);
        check("mid_rst_frame_busy", frame_busy, 1'b0);
        check("mid_rst_overflow", overflow, 1'b0);
        check("mid_rst_drop_cnt", drop_cnt, 16'h0000);
        exp_q.delete();
        pend_q.delete();
        model_seq = 8'h00;
        @(posedge rdclk); #1;
        rst_n = 1'b1;
        b0 = bytes_seen;
        repeat (30) @(posedge rdclk);
        #1;
        check("no_tail_after_rst", bytes_seen - b0, 0);

        // 257 frames: SEQ 00..FF then wraps to 00
        for (int f = 0; f < 257; f++) begin
            for (int i = 0; i < 4; i++) begin
                w = {$urandom, $urandom};
                push_word(w);
                pend_q.push_back(w);
            end
            flush_frames();
            wait_drain(200);
        end
        check("seq_wrap_model", model_seq, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
